// File: rtl/mips_defs.sv
// Shared definitions for the MIPS core: write-back control bit positions,
// default data/index widths and the hardwired zero register index.
package mips_defs;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ADDR_W_DEF     = 5;
  localparam int unsigned CTLWB_REGWRITE = 1;
  localparam int unsigned CTLWB_MEMTOREG = 0;
  localparam int unsigned REG_ZERO       = 0;

  typedef enum logic [1:0] {
    CTLWB_NONE = 2'b00,
    CTLWB_RSVD = 2'b01,
    CTLWB_ALU  = 2'b10,
    CTLWB_LOAD = 2'b11
  } ctlwb_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: one write port, two combinational read
// ports with same-cycle write bypass, synchronous clear, r0 reads as zero.
module regfile_2r1w
  import mips_defs::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ZERO_IDX)) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass is not gated by rst: a live write is still visible on the read ports.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != ZERO_IDX) begin
      rdata_a = (we && (raddr_a == waddr)) ? wdata : regs[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != ZERO_IDX) begin
      rdata_b = (we && (raddr_b == waddr)) ? wdata : regs[raddr_b];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus register file: selects load vs ALU data from mem_wb,
// qualifies the write enable against r0 and commits through regfile_2r1w.
module wb_regfile
  import mips_defs::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB_ctlwb,
  input  logic [DATA_W-1:0] WB_rdata,
  input  logic [DATA_W-1:0] WB_alu_out,
  input  logic [ADDR_W-1:0] WB_rd,
  input  logic [ADDR_W-1:0] ID_rs,
  input  logic [ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0] ID_rs_data,
  output logic [DATA_W-1:0] ID_rt_data,
  output logic [DATA_W-1:0] WB_wdata,
  output logic              WB_we
);

  always_comb begin
    WB_wdata = WB_ctlwb[CTLWB_MEMTOREG] ? WB_rdata : WB_alu_out;
    WB_we    = WB_ctlwb[CTLWB_REGWRITE] && (WB_rd != ADDR_W'(REG_ZERO));
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (WB_we),
    .waddr   (WB_rd),
    .wdata   (WB_wdata),
    .raddr_a (ID_rs),
    .raddr_b (ID_rt),
    .rdata_a (ID_rs_data),
    .rdata_b (ID_rt_data)
  );

endmodule
